// File: rtl/moore_decodifica_saida.sv
// Receive side of the Moore output bus: recovers the observed machine's state (A=0 .. J=9)
// from its 4-bit output code and checks that it advances only by hold or +1 (J wraps to A).
//
// Ports:
//   CLK          - system clock, rising edge
//   RST          - synchronous active-high reset
//   S            - Moore output code from the observed machine
//   S_VALID      - S is sampled only when this is 1
//   ESTADO       - recovered state code, registered
//   ESTADO_VALID - one-cycle pulse, ESTADO was updated from a legal code
//   COD_INVALIDO - one-cycle pulse, S held an illegal code
//   FORA_SEQ     - one-cycle pulse, legal code that is neither hold nor next state
//   SINCRONIZADO - level, checker holds a valid reference state
//   ERROS        - saturating count of COD_INVALIDO plus FORA_SEQ events
module moore_decodifica_saida #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       S,
  input  logic             S_VALID,
  output logic [3:0]       ESTADO,
  output logic             ESTADO_VALID,
  output logic             COD_INVALIDO,
  output logic             FORA_SEQ,
  output logic             SINCRONIZADO,
  output logic [ERR_W-1:0] ERROS
);

  typedef enum logic [0:0] {StDessinc, StSinc} state_e;

  state_e           state_q, state_d;
  logic [3:0]       estado_q, estado_d;
  logic             estado_valid_q, estado_valid_d;
  logic             cod_invalido_q, cod_invalido_d;
  logic             fora_seq_q, fora_seq_d;
  logic [ERR_W-1:0] erros_q, erros_d;

  logic       dec_ok;
  logic [3:0] dec_val;
  logic [3:0] next_estado;
  logic       err_event;

  // Inverse of the Moore output table.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    unique case (S)
      4'd3:    dec_val = 4'd0;
      4'd4:    dec_val = 4'd1;
      4'd2:    dec_val = 4'd2;
      4'd1:    dec_val = 4'd3;
      4'd0:    dec_val = 4'd4;
      4'd9:    dec_val = 4'd5;
      4'd7:    dec_val = 4'd6;
      4'd6:    dec_val = 4'd7;
      4'd5:    dec_val = 4'd8;
      4'd15:   dec_val = 4'd9;
      default: dec_ok  = 1'b0;
    endcase
  end

  assign next_estado = (estado_q == 4'd9) ? 4'd0 : estado_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    estado_d       = estado_q;
    estado_valid_d = 1'b0;
    cod_invalido_d = 1'b0;
    fora_seq_d     = 1'b0;
    erros_d        = erros_q;
    err_event      = 1'b0;

    if (S_VALID) begin
      if (!dec_ok) begin
        // Illegal code: keep last legal state but drop the reference.
        cod_invalido_d = 1'b1;
        err_event      = 1'b1;
        state_d        = StDessinc;
      end else begin
        estado_valid_d = 1'b1;
        estado_d       = dec_val;
        state_d        = StSinc;
        // Sequence check only applies when a reference exists; a jump re-references.
        if (state_q == StSinc && dec_val != estado_q && dec_val != next_estado) begin
          fora_seq_d = 1'b1;
          err_event  = 1'b1;
        end
      end
    end

    if (err_event && (erros_q != {ERR_W{1'b1}})) begin
      erros_d = erros_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StDessinc;
      estado_q       <= 4'd0;
      estado_valid_q <= 1'b0;
      cod_invalido_q <= 1'b0;
      fora_seq_q     <= 1'b0;
      erros_q        <= '0;
    end else begin
      state_q        <= state_d;
      estado_q       <= estado_d;
      estado_valid_q <= estado_valid_d;
      cod_invalido_q <= cod_invalido_d;
      fora_seq_q     <= fora_seq_d;
      erros_q        <= erros_d;
    end
  end

  assign ESTADO       = estado_q;
  assign ESTADO_VALID = estado_valid_q;
  assign COD_INVALIDO = cod_invalido_q;
  assign FORA_SEQ     = fora_seq_q;
  assign SINCRONIZADO = (state_q == StSinc);
  assign ERROS        = erros_q;

endmodule

// File: tb/tb_moore_decodifica_saida.sv
// Bench for moore_decodifica_saida: two instances (ERR_W=8 and ERR_W=2) share stimulus and are
// compared every cycle against a table-driven model, plus directed literal expectations.
module tb_moore_decodifica_saida;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic       s_valid;

  logic [3:0] estado_a, estado_b;
  logic       ev_a, ev_b, inv_a, inv_b, fs_a, fs_b, sync_a, sync_b;
  logic [7:0] erros_a;
  logic [1:0] erros_b;

  moore_decodifica_saida #(.ERR_W(8)) u_dut8 (
    .CLK(clk), .RST(rst), .S(s), .S_VALID(s_valid),
    .ESTADO(estado_a), .ESTADO_VALID(ev_a), .COD_INVALIDO(inv_a),
    .FORA_SEQ(fs_a), .SINCRONIZADO(sync_a), .ERROS(erros_a)
  );

  moore_decodifica_saida #(.ERR_W(2)) u_dut2 (
    .CLK(clk), .RST(rst), .S(s), .S_VALID(s_valid),
    .ESTADO(estado_b), .ESTADO_VALID(ev_b), .COD_INVALIDO(inv_b),
    .FORA_SEQ(fs_b), .SINCRONIZADO(sync_b), .ERROS(erros_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Forward Moore output table: state index -> code.
  int fwd [10] = '{3, 4, 2, 1, 0, 9, 7, 6, 5, 15};
  int inv_tab [16];

  // Model state.
  int  m_est, m_errs;
  bit  m_sync, m_ev, m_inv, m_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update(input bit r, input bit v, input int code);
    int d;
    if (r) begin
      m_est = 0; m_errs = 0; m_sync = 0; m_ev = 0; m_inv = 0; m_fs = 0;
      return;
    end
    m_ev = 0; m_inv = 0; m_fs = 0;
    if (!v) return;
    d = inv_tab[code];
    if (d < 0) begin
      m_inv = 1; m_errs++; m_sync = 0;
    end else begin
      m_ev = 1;
      if (m_sync && d != m_est && d != (m_est + 1) % 10) begin
        m_fs = 1; m_errs++;
      end
      m_est  = d;
      m_sync = 1;
    end
  endtask

  task automatic compare_all();
    chk("estado8", estado_a, m_est);
    chk("estado2", estado_b, m_est);
    chk("valid8", ev_a, m_ev);
    chk("valid2", ev_b, m_ev);
    chk("invalido8", inv_a, m_inv);
    chk("invalido2", inv_b, m_inv);
    chk("fora_seq8", fs_a, m_fs);
    chk("fora_seq2", fs_b, m_fs);
    chk("sinc8", sync_a, m_sync);
    chk("sinc2", sync_b, m_sync);
    chk("erros8", erros_a, sat(m_errs, 255));
    chk("erros2", erros_b, sat(m_errs, 3));
  endtask

  // Drive one cycle, update model at the edge, compare half a cycle later.
  task automatic step(input bit r, input bit v, input int code);
    rst = r; s_valid = v; s = code[3:0];
    @(posedge clk);
    model_update(r, v, code);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int r;
    int code;
    for (int i = 0; i < 16; i++) inv_tab[i] = -1;
    for (int i = 0; i < 10; i++) inv_tab[fwd[i]] = i;

    rst = 1'b1; s_valid = 1'b0; s = 4'd0;
    @(negedge clk);
    step(1, 0, 0);
    step(1, 1, 3);
    chk("lit_reset_estado", estado_a, 0);
    chk("lit_reset_sinc", sync_a, 0);
    chk("lit_reset_erros", erros_a, 0);

    // Full A..J..A walk.
    for (int i = 0; i < 11; i++) begin
      step(0, 1, fwd[i % 10]);
      chk("lit_walk_estado", estado_a, i % 10);
      chk("lit_walk_valid", ev_a, 1);
    end
    chk("lit_walk_erros", erros_a, 0);

    // Hold at 4.
    step(0, 1, 4); step(0, 1, 2); step(0, 1, 1); step(0, 1, 0);
    step(0, 1, 0); step(0, 1, 0);
    chk("lit_hold_estado", estado_a, 4);
    chk("lit_hold_fs", fs_a, 0);

    // Jump 0 -> 2.
    step(1, 0, 0);
    step(0, 1, 3); step(0, 1, 2);
    chk("lit_jump_fs", fs_a, 1);
    chk("lit_jump_estado", estado_a, 2);
    chk("lit_jump_erros", erros_a, 1);
    chk("lit_jump_sinc", sync_a, 1);
    step(0, 0, 0);
    chk("lit_jump_fs_drop", fs_a, 0);

    // Illegal code then resync.
    step(1, 0, 0);
    step(0, 1, 3); step(0, 1, 4); step(0, 1, 8);
    chk("lit_ill_inv", inv_a, 1);
    chk("lit_ill_sinc", sync_a, 0);
    chk("lit_ill_estado", estado_a, 1);
    step(0, 1, 5);
    chk("lit_resync_estado", estado_a, 8);
    chk("lit_resync_fs", fs_a, 0);
    chk("lit_resync_erros", erros_a, 1);

    // Saturation on the narrow instance.
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, (i < 5) ? 10 + i : 8);
      chk("lit_sat_inv2", inv_b, 1);
      chk("lit_sat_erros2", erros_b, (i < 3) ? i + 1 : 3);
    end

    // S_VALID low with toggling S, then reset at state 6.
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, fwd[i]);
    for (int i = 0; i < 8; i++) step(0, 0, $urandom_range(0, 15));
    chk("lit_idle_estado", estado_a, 6);
    step(1, 1, 6);
    chk("lit_mid_rst_estado", estado_a, 0);
    chk("lit_mid_rst_sinc", sync_a, 0);
    step(0, 1, 6);
    chk("lit_after_rst_estado", estado_a, 7);
    chk("lit_after_rst_erros", erros_a, 0);

    // Randomized run, biased toward in-sequence traffic.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      code = fwd[(m_est + 1) % 10];
      else if (r < 70) code = fwd[m_est];
      else if (r < 85) code = fwd[$urandom_range(0, 9)];
      else             code = $urandom_range(0, 15);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), code);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
